uart_deserializer: RTL and testbench

UART_DESERIALIZER -- requirements
Module: uart_deserializer

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_deserializer.sv | 81 ++++++++
 tb/tb_uart_deserializer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, oversample constant and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int OVS = 16;
  function automatic int calc_div(input int clkfreq, input int baud);
    int d;
    d = (clkfreq + baud * OVS / 2) / (baud * OVS);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: enable-able, restartable oversample tick (clk, rst, en, restart -> tick), first tick on the first enabled cycle
module uart_baud_tick #(
  parameter int div = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int W = div > 1 ? $clog2(div) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || !en || restart) cnt <= '0;
    else cnt <= (cnt == W'(div - 1)) ? '0 : cnt + 1'b1;
  assign tick = en && cnt == '0;
endmodule

// File: rtl/uart_deserializer.sv
// uart_deserializer: 16x-oversampled 8N1 UART receiver (clk, rst, serial_in -> data, ready, framing_err, busy)
module uart_deserializer
  import uart_pkg::*;
#(
  parameter int clkfreq = 50000000,
  parameter int baud = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data,
  output logic       ready,
  output logic       framing_err,
  output logic       busy
);
  localparam int DIV = calc_div(clkfreq, baud);
  localparam int PW = $clog2(OVS);
  logic rx_m, rx_s, rx_p;
  logic [1:0] warm;
  state_t state, state_n;
  logic [PW-1:0] ph;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic s7, s8, tick, start_edge, mid, last, maj;
  uart_baud_tick #(.div(DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(state != IDLE),
    .restart(start_edge),
    .tick(tick)
  );
  assign start_edge = state == IDLE && warm == 2'd3 && rx_p && !rx_s;
  assign mid = tick && ph == PW'(9);
  assign last = tick && ph == PW'(OVS - 1);
  assign maj = (s7 & s8) | (rx_s & (s7 | s8));
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      warm <= 2'd0;
    end else begin
      rx_m <= serial_in;
      rx_s <= rx_m;
      rx_p <= rx_s;
      warm <= warm + {1'b0, warm != 2'd3};
    end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_edge ? START : IDLE;
      START:   state_n = (mid && maj) ? IDLE : last ? DATA : START;
      DATA:    state_n = (last && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = mid ? (maj ? IDLE : BREAK) : STOP;
      BREAK:   state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      ph <= '0;
      bit_idx <= 3'd0;
      shreg <= 8'h00;
      s7 <= 1'b0;
      s8 <= 1'b0;
      data <= 8'h00;
      ready <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      ph <= (state == IDLE) ? PW'(1) : ph + {{(PW-1){1'b0}}, tick};
      bit_idx <= (state == IDLE) ? 3'd0 : bit_idx + {2'b0, state == DATA && last};
      if (tick && ph == PW'(7)) s7 <= rx_s;
      if (tick && ph == PW'(8)) s8 <= rx_s;
      if (state == DATA && mid) shreg <= {maj, shreg[7:1]};
      if (state == STOP && mid && maj) data <= shreg;
      ready <= state == STOP && mid && maj;
      framing_err <= state == STOP && mid && !maj;
    end
endmodule

// File: tb/tb_uart_deserializer.sv
// tb_uart_deserializer: scoreboard bench for uart_deserializer at 1.6 MHz / 10 kbaud
module tb_uart_deserializer;
  localparam int BIT = 160;
  localparam int DIV = 10;
  localparam int LMAX = 2 + BIT * 19 / 2 + 3;
  typedef struct {
    logic [7:0] b;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic [7:0] data;
  logic ready, framing_err, busy;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_rdy = 0;
  int n_ferr = 0;
  logic [7:0] last_data = 8'h00;
  exp_t sb[$];
  uart_deserializer #(.clkfreq(1600000), .baud(10000)) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .data(data),
    .ready(ready),
    .framing_err(framing_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int spike, input int len);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0 && stop) sb.push_back('{b, cyc});
      serial_in = fr[i / BIT] ^ (i == spike);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (ready || framing_err) check("ready_ferr_excl", 32'(ready & framing_err), 0);
    if (ready) begin
      n_rdy <= n_rdy + 1;
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data", data, e.b);
        check("latency_ok", 32'(cyc - e.t <= LMAX), 1);
      end
    end
    if (framing_err) n_ferr <= n_ferr + 1;
    if (!ready && !rst && data !== last_data) check("data_stable", data, last_data);
    last_data <= data;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    wait_clks(5);
    check("rst_data", data, 8'h00);
    check("rst_ready", ready, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clks(20);
    send(8'h55, 1'b1, -1, 10 * BIT);
    wait_clks(20);
    check("f55_ready_cnt", n_rdy, 1);
    check("f55_ferr_cnt", n_ferr, 0);
    check("f55_busy", busy, 0);
    check("f55_data", data, 8'h55);
    serial_in = 1'b0;
    wait_clks(20);
    check("glitch_busy", busy, 1);
    wait_clks(20);
    serial_in = 1'b1;
    wait_clks(60);
    check("glitch_idle", busy, 0);
    check("glitch_ready_cnt", n_rdy, 1);
    check("glitch_ferr_cnt", n_ferr, 0);
    wait_clks(200);
    send(8'hA3, 1'b0, -1, 10 * BIT);
    wait_clks(2000);
    check("ferr_cnt", n_ferr, 1);
    check("ferr_ready_cnt", n_rdy, 1);
    check("ferr_data_held", data, 8'h55);
    check("break_busy", busy, 1);
    serial_in = 1'b1;
    wait_clks(20);
    check("break_exit", busy, 0);
    check("break_no_pulse", n_ferr, 1);
    send(8'h0F, 1'b1, -1, 10 * BIT);
    wait_clks(200);
    check("f0f_data", data, 8'h0F);
    send(8'h00, 1'b1, -1, 10 * BIT);
    send(8'hFF, 1'b1, -1, 10 * BIT);
    wait_clks(200);
    check("b2b_ready_cnt", n_rdy, 4);
    check("b2b_data", data, 8'hFF);
    send(8'hC6, 1'b1, 4 * BIT + 7 * DIV + 1, 10 * BIT);
    wait_clks(200);
    check("spike_data", data, 8'hC6);
    check("spike_ready_cnt", n_rdy, 5);
    send(8'h5A, 1'b0, -1, 4 * BIT + BIT / 2);
    @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check("abort_data", data, 8'h00);
    check("abort_busy", busy, 0);
    wait_clks(1000);
    check("low_line_busy", busy, 0);
    check("low_line_ready_cnt", n_rdy, 5);
    check("low_line_ferr_cnt", n_ferr, 1);
    serial_in = 1'b1;
    wait_clks(50);
    send(8'h3C, 1'b1, -1, 10 * BIT);
    wait_clks(200);
    check("f3c_data", data, 8'h3C);
    check("sb_drained", sb.size(), 0);
    check("ready_total", n_rdy, 6);
    check("ferr_total", n_ferr, 1);
    check("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
